// File: rtl/uart_program_loader.sv
// Serial program loader: receives 8N1 UART bytes, pairs them high-byte-first into
// 16-bit instructions and writes them sequentially into the instruction store.
// load_done goes high with the final write and stays set until RST.
`timescale 1ns / 1ps

module uart_program_loader #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UART_TXD_IN,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        load_done,
  output logic        frame_err
);

  localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CW       = $clog2(BIT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  // Receiver state
  logic              sync1_q, sync2_q;
  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              byte_valid_q;
  logic              frame_err_q;

  // Assembler state
  logic              hi_pending_q, hi_pending_d;
  logic [7:0]        hi_q, hi_d;
  logic              wr_en_q, wr_en_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [5:0]        addr_q, addr_d;
  logic              load_done_q, load_done_d;

  // Two-flop synchronizer; idles high so reset looks like an idle line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= UART_TXD_IN;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM: start-bit validation at half a bit, then mid-bit sampling
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!sync2_q) begin
            cnt_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == CW'(HALF_CYC - 1)) begin
            cnt_q <= '0;
            if (!sync2_q) begin
              bit_idx_q <= '0;
              state_q   <= StData;
            end else begin
              // Line went back high: a glitch, not a start bit
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CW'(BIT_CYC - 1)) begin
            cnt_q     <= '0;
            shift_q   <= {sync2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CW'(BIT_CYC - 1)) begin
            cnt_q <= '0;
            if (sync2_q) byte_valid_q <= 1'b1;
            else         frame_err_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte-pair assembler and address counter next state
  always_comb begin
    hi_pending_d = hi_pending_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    load_done_d  = load_done_q;
    // Address advances the cycle after the strobe so it is stable during it
    addr_d       = wr_en_q ? addr_q + 6'd1 : addr_q;
    if (frame_err_q) begin
      hi_pending_d = 1'b0;
    end else if (byte_valid_q && !load_done_q) begin
      // shift_q is still intact here: a new frame cannot reach DATA this soon
      if (!hi_pending_q) begin
        hi_d         = shift_q;
        hi_pending_d = 1'b1;
      end else begin
        wr_en_d      = 1'b1;
        wr_data_d    = {hi_q, shift_q};
        hi_pending_d = 1'b0;
        if (addr_q == 6'(DEPTH - 1)) load_done_d = 1'b1;
      end
    end
  end

  // Assembler registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_pending_q <= 1'b0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      addr_q       <= '0;
      load_done_q  <= 1'b0;
    end else begin
      hi_pending_q <= hi_pending_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      addr_q       <= addr_d;
      load_done_q  <= load_done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q[4:0];
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at BIT_CYC = 10 (1 MHz clock, 100 kbaud).
`timescale 1ns / 1ps

module tb_uart_program_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UART_TXD_IN = 1'b1;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        load_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  real bit_ns = 100.0;

  // Write/error log collected by the monitor
  logic [4:0]  addr_log[$];
  logic [15:0] data_log[$];
  logic        ld_log[$];
  int          fe_cnt = 0;
  int          wr_wide = 0;
  int          fe_wide = 0;
  logic        wr_prev = 1'b0;
  logic        fe_prev = 1'b0;

  uart_program_loader #(
    .CLK_HZ(1000000),
    .BAUD  (100000),
    .DEPTH (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .UART_TXD_IN(UART_TXD_IN),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  // Sample outputs on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (!RST) begin
      if (wr_en) begin
        addr_log.push_back(wr_addr);
        data_log.push_back(wr_data);
        ld_log.push_back(load_done);
      end
      if (frame_err) fe_cnt++;
      if (wr_en && wr_prev) wr_wide++;
      if (frame_err && fe_prev) fe_wide++;
      wr_prev = wr_en;
      fe_prev = frame_err;
    end
  end

  task automatic clear_mon();
    addr_log.delete();
    data_log.delete();
    ld_log.delete();
    fe_cnt  = 0;
    wr_wide = 0;
    fe_wide = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    UART_TXD_IN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    UART_TXD_IN = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      UART_TXD_IN = b[i];
      #(bit_ns);
    end
    UART_TXD_IN = stop_bit;
    #(bit_ns);
    UART_TXD_IN = 1'b1;
  endtask

  task automatic settle();
    repeat (30) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    UART_TXD_IN = 1'b1;
    #23;
    checks++;
    if ({wr_en, wr_addr, wr_data, load_done, frame_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 000000",
               {wr_en, wr_addr, wr_data, load_done, frame_err});
    end
    do_reset();
  endtask

  task automatic test_single_word();
    do_reset();
    send_byte(8'h1A, 1'b1);
    send_byte(8'h35, 1'b1);
    settle();
    checks++;
    if (data_log.size() !== 1) begin
      errors++;
      $display("FAIL single_wr_count: got %0d, want 1", data_log.size());
    end
    if (data_log.size() >= 1) begin
      checks++;
      if (data_log[0] !== 16'h1A35 || addr_log[0] !== 5'd0) begin
        errors++;
        $display("FAIL single_wr: got addr %0d data %h, want addr 0 data 1a35",
                 addr_log[0], data_log[0]);
      end
    end
    checks++;
    if (load_done !== 1'b0 || fe_cnt !== 0 || wr_wide !== 0) begin
      errors++;
      $display("FAIL single_flags: got load_done %b fe %0d wide %0d, want 0 0 0",
               load_done, fe_cnt, wr_wide);
    end
    checks++;
    if (wr_addr !== 5'd1) begin
      errors++;
      $display("FAIL single_addr_incr: got %0d, want 1", wr_addr);
    end
  endtask

  task automatic test_full_load();
    int bad;
    logic [4:0]  a_snap;
    logic [15:0] d_snap;
    do_reset();
    for (int w = 0; w < 32; w++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'(w), 1'b1);
    end
    settle();
    checks++;
    if (data_log.size() !== 32) begin
      errors++;
      $display("FAIL full_wr_count: got %0d, want 32", data_log.size());
    end
    bad = 0;
    for (int w = 0; w < 32 && w < data_log.size(); w++) begin
      if (addr_log[w] !== 5'(w) || data_log[w] !== 16'(w) || ld_log[w] !== (w == 31))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_wr_contents: got %0d bad entries, want 0", bad);
    end
    checks++;
    if (load_done !== 1'b1 || wr_data !== 16'h001F) begin
      errors++;
      $display("FAIL full_done: got load_done %b data %h, want 1 001f", load_done, wr_data);
    end
    a_snap = wr_addr;
    d_snap = wr_data;
    send_byte(8'hFF, 1'b1);
    send_byte(8'hEE, 1'b1);
    settle();
    checks++;
    if (data_log.size() !== 32 || wr_addr !== a_snap || wr_data !== d_snap) begin
      errors++;
      $display("FAIL full_ignore: got %0d writes addr %0d data %h, want 32 %0d %h",
               data_log.size(), wr_addr, wr_data, a_snap, d_snap);
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL full_sticky: got %b, want 1", load_done);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    #(2.0 * bit_ns);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    settle();
    checks++;
    if (fe_cnt !== 1 || fe_wide !== 0) begin
      errors++;
      $display("FAIL fe_pulse: got %0d pulses %0d wide, want 1 0", fe_cnt, fe_wide);
    end
    checks++;
    if (data_log.size() !== 1) begin
      errors++;
      $display("FAIL fe_wr_count: got %0d, want 1", data_log.size());
    end
    if (data_log.size() >= 1) begin
      checks++;
      if (data_log[0] !== 16'h1234 || addr_log[0] !== 5'd0) begin
        errors++;
        $display("FAIL fe_wr: got addr %0d data %h, want addr 0 data 1234",
                 addr_log[0], data_log[0]);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    UART_TXD_IN = 1'b0;
    #30;
    UART_TXD_IN = 1'b1;
    #(2.0 * bit_ns);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    settle();
    checks++;
    if (fe_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_fe: got %0d, want 0", fe_cnt);
    end
    checks++;
    if (data_log.size() !== 1 || (data_log.size() >= 1 && data_log[0] !== 16'h55AA)) begin
      errors++;
      $display("FAIL glitch_wr: got %0d writes, first %h, want 1 55aa",
               data_log.size(), data_log.size() >= 1 ? data_log[0] : 16'h0);
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h77, 1'b1);
    // Start of the next byte, interrupted during its data bits
    UART_TXD_IN = 1'b0;
    #(bit_ns);
    UART_TXD_IN = 1'b1;
    #(bit_ns);
    UART_TXD_IN = 1'b0;
    #(bit_ns);
    checks++;
    if (wr_addr !== 5'd1 || wr_data !== 16'h1122) begin
      errors++;
      $display("FAIL pre_reset: got addr %0d data %h, want 1 1122", wr_addr, wr_data);
    end
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, load_done, frame_err} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: got %h, want 000000",
               {wr_en, wr_addr, wr_data, load_done, frame_err});
    end
    UART_TXD_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    clear_mon();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    settle();
    checks++;
    if (data_log.size() !== 1 ||
        (data_log.size() >= 1 && (data_log[0] !== 16'h0102 || addr_log[0] !== 5'd0))) begin
      errors++;
      $display("FAIL post_reset_wr: got %0d writes, first addr %0d data %h, want 1 0 0102",
               data_log.size(), data_log.size() >= 1 ? addr_log[0] : 5'd0,
               data_log.size() >= 1 ? data_log[0] : 16'h0);
    end
  endtask

  task automatic test_baud_tolerance();
    logic [15:0] words[8];
    int bad;
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789,
              16'h1357, 16'h2468, 16'hFEDC, 16'h8001};
    do_reset();
    for (int w = 0; w < 8; w++) begin
      bit_ns = (w < 4) ? 98.0 : 102.0;
      send_byte(words[w][15:8], 1'b1);
      send_byte(words[w][7:0], 1'b1);
    end
    bit_ns = 100.0;
    settle();
    checks++;
    if (data_log.size() !== 8 || fe_cnt !== 0) begin
      errors++;
      $display("FAIL baud_count: got %0d writes %0d frame errors, want 8 0",
               data_log.size(), fe_cnt);
    end
    bad = 0;
    for (int w = 0; w < 8 && w < data_log.size(); w++) begin
      if (data_log[w] !== words[w] || addr_log[w] !== 5'(w)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL baud_contents: got %0d bad words, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_frame_err();
    test_glitch();
    test_mid_frame_reset();
    test_baud_tolerance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
